// File: rtl/alu_op_decoder.sv
// alu_op_decoder: RV32I decode stage producing registered ALU operands, op code and control flags
// behind a single-entry valid/ready register with flush and a saturating illegal-instruction counter.
module alu_op_decoder #(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [31:0]          instr_i,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          rs1_data_i,
    input  logic [31:0]          rs2_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    input  logic                 out_ready_i,
    output logic                 out_valid_o,
    output logic [31:0]          alu_a_o,
    output logic [31:0]          alu_b_o,
    output logic [3:0]           alu_op_o,
    output logic [4:0]           rd_o,
    output logic                 reg_write_o,
    output logic                 branch_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic [2:0]           funct3_o,
    output logic [31:0]          rs2_fwd_o,
    output logic                 illegal_o,
    output logic [ILL_CNT_W-1:0] ill_cnt_o
);
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_SLL = 4'b0010, OP_SLT = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100, OP_XOR = 4'b0101, OP_SRL = 4'b0110, OP_SRA = 4'b0111;
    localparam logic [3:0] OP_OR = 4'b1000, OP_AND = 4'b1001, OP_PASSB = 4'b1111;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_u;
    logic [3:0]  d_op;
    logic [31:0] d_a, d_b;
    logic        d_rw, d_br, d_mr, d_mw, d_ill;
    logic        accept;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_u  = {instr_i[31:12], 12'b0};

    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    // alt selects sub for funct3 000 and sra for funct3 101
    function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? OP_SUB : OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return alt ? OP_SRA : OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    always_comb begin
        d_op  = OP_ADD;
        d_a   = rs1_data_i;
        d_b   = rs2_data_i;
        d_rw  = 1'b0;
        d_br  = 1'b0;
        d_mr  = 1'b0;
        d_mw  = 1'b0;
        d_ill = 1'b0;
        case (opcode)
            7'b0110011: begin
                d_rw  = 1'b1;
                d_op  = alu_f3(funct3, funct7[5]);
                d_ill = funct7 != 7'b0000000 && funct7 != 7'b0100000;
            end
            7'b0010011: begin
                d_rw = 1'b1;
                d_op = alu_f3(funct3, funct3 == 3'b101 && funct7[5]);
                d_b  = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'b0, instr_i[24:20]} : imm_i;
            end
            7'b0110111: begin
                d_rw = 1'b1;
                d_op = OP_PASSB;
                d_b  = imm_u;
            end
            7'b0010111: begin
                d_rw = 1'b1;
                d_a  = pc_i;
                d_b  = imm_u;
            end
            7'b1101111, 7'b1100111: begin
                d_rw = 1'b1;
                d_a  = pc_i;
                d_b  = 32'd4;
            end
            7'b0000011: begin
                d_rw = 1'b1;
                d_mr = 1'b1;
                d_b  = imm_i;
            end
            7'b0100011: begin
                d_mw = 1'b1;
                d_b  = imm_s;
            end
            7'b1100011: begin
                d_br  = 1'b1;
                d_op  = funct3[2] ? (funct3[1] ? OP_SLTU : OP_SLT) : OP_SUB;
                d_ill = funct3[2:1] == 2'b01;
            end
            default: d_ill = 1'b1;
        endcase
        d_rw = d_rw && rd != 5'd0 && !d_ill;
        d_br = d_br && !d_ill;
        d_mr = d_mr && !d_ill;
        d_mw = d_mw && !d_ill;
        d_op = d_ill ? OP_ADD : d_op;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            alu_op_o    <= '0;
            rd_o        <= '0;
            reg_write_o <= 1'b0;
            branch_o    <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            funct3_o    <= '0;
            rs2_fwd_o   <= '0;
            illegal_o   <= 1'b0;
            ill_cnt_o   <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            alu_a_o     <= d_a;
            alu_b_o     <= d_b;
            alu_op_o    <= d_op;
            rd_o        <= rd;
            reg_write_o <= d_rw;
            branch_o    <= d_br;
            mem_read_o  <= d_mr;
            mem_write_o <= d_mw;
            funct3_o    <= funct3;
            rs2_fwd_o   <= rs2_data_i;
            illegal_o   <= d_ill;
            if (d_ill && !(&ill_cnt_o))
                ill_cnt_o <= ill_cnt_o + 1'b1;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end
endmodule
